usb_transaction_controller: RTL and testbench



---
 rtl/usb_transaction_controller.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_usb_transaction_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_transaction_controller.sv
// Full-speed USB device transaction sequencer: accepts tokens, picks the
// ACK/NAK/STALL/DATAx response, owns data toggles and address, detects bus reset.
module usb_transaction_controller #(
  parameter int NUM_EP       = 4,
  parameter int TIMEOUT_CLKS = 72,
  parameter int RESET_CLKS   = 120
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              line_se0_i,
  input  logic              rx_pkt_valid_i,
  input  logic [3:0]        rx_pid_i,
  input  logic [6:0]        rx_address_i,
  input  logic [3:0]        rx_endpoint_i,
  input  logic              rx_crc_ok_i,
  input  logic [NUM_EP-1:0] ep_in_ready_i,
  input  logic [NUM_EP-1:0] ep_out_ready_i,
  input  logic [NUM_EP-1:0] ep_stall_i,
  input  logic [6:0]        new_address_i,
  input  logic              new_address_valid_i,
  input  logic              tx_done_i,
  output logic              tx_req_o,
  output logic [3:0]        tx_pid_o,
  output logic              tx_is_data_o,
  output logic [3:0]        tx_endpoint_o,
  output logic              rx_commit_o,
  output logic              rx_discard_o,
  output logic              in_ack_o,
  output logic              setup_seen_o,
  output logic [3:0]        cur_endpoint_o,
  output logic [6:0]        device_address_o,
  output logic              bus_reset_o
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int TMW = $clog2(TIMEOUT_CLKS + 1);
  localparam int SEW = $clog2(RESET_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT_DATA, S_SEND_HS, S_SEND_DATA, S_WAIT_ACK
  } state_e;

  typedef struct packed {
    logic [3:0] pid;
    logic       is_data;
  } tx_cmd_t;

  state_e            state_q, state_d;
  logic [3:0]        cur_ep_q, cur_ep_d;
  logic [3:0]        tok_pid_q, tok_pid_d;
  tx_cmd_t           tx_q, tx_d;
  logic              tx_req_q, tx_req_d;
  logic              rx_commit_q, rx_commit_d;
  logic              rx_discard_q, rx_discard_d;
  logic              in_ack_q, in_ack_d;
  logic              setup_seen_q, setup_seen_d;
  logic              bus_reset_q, bus_reset_d;
  logic [6:0]        dev_addr_q, dev_addr_d;
  logic [6:0]        pend_addr_q, pend_addr_d;
  logic              pend_vld_q, pend_vld_d;
  logic [NUM_EP-1:0] tog_in_q, tog_in_d;
  logic [NUM_EP-1:0] tog_out_q, tog_out_d;
  logic [TMW-1:0]    tmo_q, tmo_d;
  logic [SEW-1:0]    se0_cnt_q, se0_cnt_d;

  logic [EPW-1:0] ep_idx;
  logic           tok_ok, is_data_pid, tmo_exp, bus_rst_det;
  logic           hs_send;
  logic [3:0]     hs_pid;

  assign ep_idx      = cur_ep_q[EPW-1:0];
  assign is_data_pid = (rx_pid_i == PID_DATA0) || (rx_pid_i == PID_DATA1);
  assign tok_ok      = rx_pkt_valid_i && rx_crc_ok_i && (rx_address_i == dev_addr_q) &&
                       ({1'b0, rx_endpoint_i} < 5'(NUM_EP)) &&
                       ((rx_pid_i == PID_OUT) || (rx_pid_i == PID_IN) || (rx_pid_i == PID_SETUP));
  assign tmo_exp     = (tmo_q == TMW'(TIMEOUT_CLKS - 1));
  // Fires only on the transition into saturation, so one pulse per SE0 episode.
  assign bus_rst_det = line_se0_i && (se0_cnt_q == SEW'(RESET_CLKS - 1));

  always_comb begin
    state_d      = state_q;
    cur_ep_d     = cur_ep_q;
    tok_pid_d    = tok_pid_q;
    tx_d         = tx_q;
    tx_req_d     = 1'b0;
    rx_commit_d  = 1'b0;
    rx_discard_d = 1'b0;
    in_ack_d     = 1'b0;
    setup_seen_d = 1'b0;
    bus_reset_d  = 1'b0;
    dev_addr_d   = dev_addr_q;
    pend_addr_d  = pend_addr_q;
    pend_vld_d   = pend_vld_q;
    tog_in_d     = tog_in_q;
    tog_out_d    = tog_out_q;
    tmo_d        = '0;
    hs_send      = 1'b0;
    hs_pid       = PID_ACK;

    case (state_q)
      S_IDLE: begin
        if (tok_ok) begin
          cur_ep_d  = rx_endpoint_i;
          tok_pid_d = rx_pid_i;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (tok_pid_q == PID_IN) begin
          if (ep_stall_i[ep_idx]) begin
            hs_send = 1'b1;
            hs_pid  = PID_STALL;
          end else if (ep_in_ready_i[ep_idx]) begin
            state_d  = S_SEND_DATA;
            tx_req_d = 1'b1;
            tx_d     = '{pid: (tog_in_q[ep_idx] ? PID_DATA1 : PID_DATA0), is_data: 1'b1};
          end else begin
            hs_send = 1'b1;
            hs_pid  = PID_NAK;
          end
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        tmo_d = tmo_q + TMW'(1);
        if (rx_pkt_valid_i) begin
          state_d = S_IDLE;
          if (is_data_pid) begin
            if (!rx_crc_ok_i) begin
              rx_discard_d = 1'b1;
            end else if (tok_pid_q == PID_SETUP) begin
              hs_send           = 1'b1;
              rx_commit_d       = 1'b1;
              setup_seen_d      = 1'b1;
              tog_out_d[ep_idx] = 1'b1;
              tog_in_d[ep_idx]  = 1'b1;
            end else if (ep_stall_i[ep_idx]) begin
              hs_send      = 1'b1;
              hs_pid       = PID_STALL;
              rx_discard_d = 1'b1;
            end else if (rx_pid_i[3] != tog_out_q[ep_idx]) begin
              // Host missed our last ACK and resent: acknowledge, keep nothing.
              hs_send      = 1'b1;
              rx_discard_d = 1'b1;
            end else if (!ep_out_ready_i[ep_idx]) begin
              hs_send      = 1'b1;
              hs_pid       = PID_NAK;
              rx_discard_d = 1'b1;
            end else begin
              hs_send           = 1'b1;
              rx_commit_d       = 1'b1;
              tog_out_d[ep_idx] = ~tog_out_q[ep_idx];
            end
          end
        end else if (tmo_exp) begin
          state_d = S_IDLE;
        end
      end
      S_SEND_HS: begin
        if (tx_done_i) begin
          state_d = S_IDLE;
          tx_d    = '0;
        end
      end
      S_SEND_DATA: begin
        if (tx_done_i) begin
          state_d = S_WAIT_ACK;
          tx_d    = '0;
        end
      end
      S_WAIT_ACK: begin
        tmo_d = tmo_q + TMW'(1);
        if (rx_pkt_valid_i) begin
          state_d = S_IDLE;
          if ((rx_pid_i == PID_ACK) && rx_crc_ok_i) begin
            in_ack_d         = 1'b1;
            tog_in_d[ep_idx] = ~tog_in_q[ep_idx];
            // Status stage of SET_ADDRESS completes on the ep0 IN ACK.
            if (pend_vld_q && (cur_ep_q == 4'd0)) begin
              dev_addr_d = pend_addr_q;
              pend_vld_d = 1'b0;
            end
          end
        end else if (tmo_exp) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (hs_send) begin
      state_d  = S_SEND_HS;
      tx_req_d = 1'b1;
      tx_d     = '{pid: hs_pid, is_data: 1'b0};
    end

    if (new_address_valid_i) begin
      pend_addr_d = new_address_i;
      pend_vld_d  = 1'b1;
    end

    if (!line_se0_i)                         se0_cnt_d = '0;
    else if (se0_cnt_q == SEW'(RESET_CLKS)) se0_cnt_d = se0_cnt_q;
    else                                     se0_cnt_d = se0_cnt_q + SEW'(1);

    if (bus_rst_det) begin
      state_d      = S_IDLE;
      bus_reset_d  = 1'b1;
      dev_addr_d   = '0;
      pend_addr_d  = '0;
      pend_vld_d   = 1'b0;
      tog_in_d     = '0;
      tog_out_d    = '0;
      tmo_d        = '0;
      tx_d         = '0;
      tx_req_d     = 1'b0;
      rx_commit_d  = 1'b0;
      rx_discard_d = 1'b0;
      in_ack_d     = 1'b0;
      setup_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cur_ep_q     <= '0;
      tok_pid_q    <= '0;
      tx_q         <= '0;
      tx_req_q     <= 1'b0;
      rx_commit_q  <= 1'b0;
      rx_discard_q <= 1'b0;
      in_ack_q     <= 1'b0;
      setup_seen_q <= 1'b0;
      bus_reset_q  <= 1'b0;
      dev_addr_q   <= '0;
      pend_addr_q  <= '0;
      pend_vld_q   <= 1'b0;
      tog_in_q     <= '0;
      tog_out_q    <= '0;
      tmo_q        <= '0;
      se0_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_ep_q     <= cur_ep_d;
      tok_pid_q    <= tok_pid_d;
      tx_q         <= tx_d;
      tx_req_q     <= tx_req_d;
      rx_commit_q  <= rx_commit_d;
      rx_discard_q <= rx_discard_d;
      in_ack_q     <= in_ack_d;
      setup_seen_q <= setup_seen_d;
      bus_reset_q  <= bus_reset_d;
      dev_addr_q   <= dev_addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_vld_q   <= pend_vld_d;
      tog_in_q     <= tog_in_d;
      tog_out_q    <= tog_out_d;
      tmo_q        <= tmo_d;
      se0_cnt_q    <= se0_cnt_d;
    end
  end

  assign tx_req_o         = tx_req_q;
  assign tx_pid_o         = tx_q.pid;
  assign tx_is_data_o     = tx_q.is_data;
  assign tx_endpoint_o    = cur_ep_q;
  assign rx_commit_o      = rx_commit_q;
  assign rx_discard_o     = rx_discard_q;
  assign in_ack_o         = in_ack_q;
  assign setup_seen_o     = setup_seen_q;
  assign cur_endpoint_o   = cur_ep_q;
  assign device_address_o = dev_addr_q;
  assign bus_reset_o      = bus_reset_q;

endmodule

// File: tb/tb_usb_transaction_controller.sv
// Directed bench for usb_transaction_controller: hand-computed responses for
// IN/OUT/SETUP flows, addressing, stall, timeout and bus reset.
module tb_usb_transaction_controller;

  localparam logic [3:0] OUT_P = 4'b0001, IN_P = 4'b1001, SETUP_P = 4'b1101;
  localparam logic [3:0] D0 = 4'b0011, D1 = 4'b1011;
  localparam logic [3:0] ACK_P = 4'b0010, NAK_P = 4'b1010, STALL_P = 4'b1110;

  logic       clk, rst_n, line_se0, rx_pkt_valid, rx_crc_ok;
  logic [3:0] rx_pid, rx_endpoint;
  logic [6:0] rx_address, new_address;
  logic [3:0] ep_in_ready, ep_out_ready, ep_stall;
  logic       new_address_valid, tx_done;
  logic       tx_req, tx_is_data, rx_commit, rx_discard, in_ack, setup_seen, bus_reset;
  logic [3:0] tx_pid, tx_endpoint, cur_endpoint;
  logic [6:0] device_address;

  int errs = 0;
  int nchk = 0;

  usb_transaction_controller #(.NUM_EP(4), .TIMEOUT_CLKS(72), .RESET_CLKS(120)) dut (
    .clk_i(clk), .rst_ni(rst_n), .line_se0_i(line_se0),
    .rx_pkt_valid_i(rx_pkt_valid), .rx_pid_i(rx_pid), .rx_address_i(rx_address),
    .rx_endpoint_i(rx_endpoint), .rx_crc_ok_i(rx_crc_ok),
    .ep_in_ready_i(ep_in_ready), .ep_out_ready_i(ep_out_ready), .ep_stall_i(ep_stall),
    .new_address_i(new_address), .new_address_valid_i(new_address_valid),
    .tx_done_i(tx_done), .tx_req_o(tx_req), .tx_pid_o(tx_pid), .tx_is_data_o(tx_is_data),
    .tx_endpoint_o(tx_endpoint), .rx_commit_o(rx_commit), .rx_discard_o(rx_discard),
    .in_ack_o(in_ack), .setup_seen_o(setup_seen), .cur_endpoint_o(cur_endpoint),
    .device_address_o(device_address), .bus_reset_o(bus_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                     input logic crc);
    rx_pkt_valid = 1'b1; rx_pid = pid; rx_address = addr; rx_endpoint = ep; rx_crc_ok = crc;
    tick();
    rx_pkt_valid = 1'b0; rx_crc_ok = 1'b0;
  endtask

  task automatic txdone();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic watch_txreq(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_req) cnt++;
    end
  endtask

  initial begin
    int txr, br, first_at;
    rst_n = 1'b0; line_se0 = 1'b0; rx_pkt_valid = 1'b0; rx_crc_ok = 1'b0;
    rx_pid = '0; rx_address = '0; rx_endpoint = '0;
    ep_in_ready = '0; ep_out_ready = '0; ep_stall = '0;
    new_address = '0; new_address_valid = 1'b0; tx_done = 1'b0;
    tick(); tick();
    check("rst_txreq", tx_req, 0);
    check("rst_pid", tx_pid, 0);
    check("rst_addr", device_address, 0);
    check("rst_busrst", bus_reset, 0);
    check("rst_commit", rx_commit, 0);
    rst_n = 1'b1;
    tick();

    // IN on ep0 at address 0: DATA0 then DATA1
    ep_in_ready = 4'b0001;
    pkt(IN_P, 7'd0, 4'd0, 1'b1);
    check("in_n1_noreq", tx_req, 0);
    tick();
    check("in_n2_req", tx_req, 1);
    check("in_pid_d0", tx_pid, D0);
    check("in_isdata", tx_is_data, 1);
    check("in_ep", tx_endpoint, 0);
    tick();
    check("txreq_pulse", tx_req, 0);
    txdone();
    pkt(ACK_P, 7'd0, 4'd0, 1'b1);
    check("in_ack1", in_ack, 1);
    pkt(IN_P, 7'd0, 4'd0, 1'b1);
    tick();
    check("in_pid_d1", tx_pid, D1);
    txdone();
    pkt(ACK_P, 7'd0, 4'd0, 1'b1);
    check("in_ack2", in_ack, 1);

    // SET_ADDRESS 5 applied on status-stage ACK
    new_address = 7'd5; new_address_valid = 1'b1;
    tick();
    new_address_valid = 1'b0;
    check("addr_pending", device_address, 0);
    pkt(IN_P, 7'd0, 4'd0, 1'b1);
    tick();
    check("addr_in_pid", tx_pid, D0);
    txdone();
    pkt(ACK_P, 7'd0, 4'd0, 1'b1);
    check("addr_applied", device_address, 5);
    pkt(IN_P, 7'd0, 4'd0, 1'b1);
    watch_txreq(4, txr);
    check("old_addr_ignored", txr, 0);

    // OUT sequence on ep1
    ep_out_ready = 4'b0010;
    pkt(OUT_P, 7'd5, 4'd1, 1'b1); tick();
    pkt(D0, 7'd0, 4'd0, 1'b1);
    check("out_req", tx_req, 1);
    check("out_ack", tx_pid, ACK_P);
    check("out_commit", rx_commit, 1);
    check("out_cur_ep", cur_endpoint, 1);
    txdone();
    pkt(OUT_P, 7'd5, 4'd1, 1'b1); tick();
    pkt(D0, 7'd0, 4'd0, 1'b1);
    check("dup_ack", tx_pid, ACK_P);
    check("dup_discard", rx_discard, 1);
    check("dup_nocommit", rx_commit, 0);
    txdone();
    ep_out_ready = 4'b0000;
    pkt(OUT_P, 7'd5, 4'd1, 1'b1); tick();
    pkt(D1, 7'd0, 4'd0, 1'b1);
    check("nak_pid", tx_pid, NAK_P);
    check("nak_discard", rx_discard, 1);
    txdone();
    ep_out_ready = 4'b0010;
    pkt(OUT_P, 7'd5, 4'd1, 1'b1); tick();
    pkt(D1, 7'd0, 4'd0, 1'b0);
    check("badcrc_discard", rx_discard, 1);
    check("badcrc_notx", tx_req, 0);
    watch_txreq(4, txr);
    check("badcrc_noresp", txr, 0);
    pkt(OUT_P, 7'd5, 4'd1, 1'b1); tick();
    pkt(D1, 7'd0, 4'd0, 1'b1);
    check("out_d1_commit", rx_commit, 1);
    txdone();

    // SETUP on ep1 forces IN toggle to DATA1
    pkt(SETUP_P, 7'd5, 4'd1, 1'b1); tick();
    pkt(D0, 7'd0, 4'd0, 1'b1);
    check("setup_ack", tx_pid, ACK_P);
    check("setup_seen", setup_seen, 1);
    check("setup_commit", rx_commit, 1);
    txdone();
    ep_in_ready = 4'b0011;
    pkt(IN_P, 7'd5, 4'd1, 1'b1); tick();
    check("setup_in_d1", tx_pid, D1);
    check("setup_in_ep", tx_endpoint, 1);
    txdone();
    pkt(ACK_P, 7'd0, 4'd0, 1'b1);
    check("setup_in_ack", in_ack, 1);

    // Stall on ep2
    ep_stall = 4'b0100;
    pkt(IN_P, 7'd5, 4'd2, 1'b1); tick();
    check("stall_pid", tx_pid, STALL_P);
    check("stall_isdata", tx_is_data, 0);
    txdone();
    ep_stall = 4'b0000;

    // WAIT_ACK timeout, retry resends same PID; ACK on last cycle still wins
    pkt(IN_P, 7'd5, 4'd0, 1'b1); tick();
    check("tmo_first_pid", tx_pid, D1);
    txdone();
    repeat (72) tick();
    pkt(IN_P, 7'd5, 4'd0, 1'b1); tick();
    check("tmo_retry_req", tx_req, 1);
    check("tmo_retry_pid", tx_pid, D1);
    txdone();
    repeat (71) tick();
    pkt(ACK_P, 7'd0, 4'd0, 1'b1);
    check("ack_at_expiry", in_ack, 1);

    // 119 SE0 clocks: no reset
    br = 0;
    line_se0 = 1'b1;
    for (int i = 0; i < 119; i++) begin tick(); if (bus_reset) br++; end
    line_se0 = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (bus_reset) br++; end
    check("se0_119_nopulse", br, 0);

    // 125 SE0 clocks overlapping a WAIT_ACK
    br = 0; first_at = 0;
    line_se0 = 1'b1;
    for (int i = 1; i <= 125; i++) begin
      if (i == 1) begin
        rx_pkt_valid = 1'b1; rx_pid = IN_P; rx_address = 7'd5; rx_endpoint = 4'd0; rx_crc_ok = 1'b1;
      end
      if (i == 2) begin rx_pkt_valid = 1'b0; rx_crc_ok = 1'b0; end
      tx_done = (i == 60);
      tick();
      if (bus_reset) begin
        br++;
        if (first_at == 0) first_at = i;
      end
    end
    tx_done = 1'b0;
    line_se0 = 1'b0;
    check("busrst_single", br, 1);
    check("busrst_cycle", first_at, 120);
    check("busrst_addr", device_address, 0);
    pkt(ACK_P, 7'd0, 4'd0, 1'b1);
    check("busrst_idle", in_ack, 0);
    pkt(OUT_P, 7'd0, 4'd1, 1'b1); tick();
    pkt(D0, 7'd0, 4'd0, 1'b1);
    check("busrst_tog_out", rx_commit, 1);
    txdone();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
